bp_be_dcache_resp_scoreboard: RTL



---
 rtl/bp_be_dcache_resp_scoreboard.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bp_be_dcache_resp_scoreboard.sv
// Response scoreboard for the BE D$ unit-test environment.
// Expected {data, mask} entries are queued by the stimulus side. Each D$ load
// response is compared in order against the queue head. The block flags
// mismatches, unexpected responses and hung requests through registered status
// outputs.
module bp_be_dcache_resp_scoreboard #(
   parameter int data_width_p      = 64,
   parameter int els_p             = 8,
   parameter int timeout_p         = 1024,
   parameter int err_count_width_p = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          exp_v_i,
   input  logic [data_width_p-1:0]       exp_data_i,
   input  logic [data_width_p-1:0]       exp_mask_i,
   output logic                          exp_ready_and_o,
   input  logic                          v_i,
   input  logic [data_width_p-1:0]       data_i,
   output logic                          mismatch_v_o,
   output logic                          error_o,
   output logic [err_count_width_p-1:0]  err_count_o,
   output logic [$clog2(els_p+1)-1:0]    outstanding_o,
   output logic                          timeout_o,
   output logic                          idle_o
);

   localparam int ptr_w_lp = $clog2(els_p);
   localparam int cnt_w_lp = $clog2(els_p+1);
   localparam int wd_w_lp  = $clog2(timeout_p);

   localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
   // Leaving e_wait when the watchdog is at timeout_p-2 means its next value
   // would be timeout_p-1; this places the timeout_o rise exactly timeout_p
   // cycles after the first outstanding push.
   localparam logic [wd_w_lp-1:0]  wd_last_lp  = wd_w_lp'(timeout_p-2);

   typedef enum logic [1:0] {e_idle, e_wait, e_timeout} state_e;

   logic [data_width_p-1:0]      data_mem [els_p];
   logic [data_width_p-1:0]      mask_mem [els_p];

   logic [ptr_w_lp-1:0]          head_q, head_d, tail_q, tail_d;
   logic [cnt_w_lp-1:0]          count_q, count_d;
   logic [wd_w_lp-1:0]           wd_q, wd_d;
   logic [err_count_width_p-1:0] err_cnt_q, err_cnt_d;
   logic                         error_q, error_d;
   logic                         mismatch_q, mismatch_d;
   state_e                       state_q, state_d;

   logic push, pop, unexp, cmp_fail, fail;

   // Queue bookkeeping, in-order compare and error accounting.
   always_comb begin
      push       = exp_v_i & (count_q != full_cnt_lp);
      pop        = v_i & (count_q != '0);
      unexp      = v_i & (count_q == '0);
      cmp_fail   = |((data_i ^ data_mem[head_q]) & mask_mem[head_q]);
      fail       = unexp | (pop & cmp_fail);

      head_d     = pop  ? head_q + ptr_w_lp'(1) : head_q;
      tail_d     = push ? tail_q + ptr_w_lp'(1) : tail_q;
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + cnt_w_lp'(1);
         2'b01:   count_d = count_q - cnt_w_lp'(1);
         default: count_d = count_q;
      endcase

      mismatch_d = fail;
      error_d    = error_q | fail;
      err_cnt_d  = err_cnt_q;
      if (fail && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + err_count_width_p'(1);
      end
   end

   // Watchdog FSM: tracks whether entries are outstanding and detects hangs.
   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      case (state_q)
         e_idle: begin
            wd_d = '0;
            if (count_d != '0) state_d = e_wait;
         end
         e_wait: begin
            if (v_i || (count_q == '0)) wd_d = '0;
            else                        wd_d = wd_q + wd_w_lp'(1);
            if (count_d == '0) begin
               state_d = e_idle;
            end else if (!v_i && (count_q != '0) && (wd_q == wd_last_lp)) begin
               state_d = e_timeout;
            end
         end
         e_timeout: begin
            state_d = e_timeout;
         end
         default: begin
            state_d = e_idle;
            wd_d    = '0;
         end
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         wd_q       <= '0;
         err_cnt_q  <= '0;
         error_q    <= 1'b0;
         mismatch_q <= 1'b0;
         state_q    <= e_idle;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         wd_q       <= wd_d;
         err_cnt_q  <= err_cnt_d;
         error_q    <= error_d;
         mismatch_q <= mismatch_d;
         state_q    <= state_d;
      end
   end

   // Expected-entry storage; contents are qualified by count, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_mem[tail_q] <= exp_data_i;
         mask_mem[tail_q] <= exp_mask_i;
      end
   end

   assign exp_ready_and_o = (count_q != full_cnt_lp);
   assign outstanding_o   = count_q;
   assign timeout_o       = (state_q == e_timeout);
   assign error_o         = error_q | timeout_o;
   assign idle_o          = (count_q == '0) & (state_q != e_timeout);
   assign mismatch_v_o    = mismatch_q;
   assign err_count_o     = err_cnt_q;

endmodule
